// File: rtl/fetch_unit_if.sv
// fetch_unit_if: groups the control, operand and PC-output signals exchanged
// between the fetch stage (slave) and its driver (decode/execute or bench).
interface fetch_unit_if;
    logic        stall;
    logic [1:0]  pc_sel;
    logic        branch_taken;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic        halt;
    logic        resume;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic [31:0] retired_count;
    logic        misalign;

    modport master (
        output stall, pc_sel, branch_taken, imm, rs1_data, halt, resume,
        input  pc, pc_plus4, fetch_valid, retired_count, misalign
    );

    modport slave (
        input  stall, pc_sel, branch_taken, imm, rs1_data, halt, resume,
        output pc, pc_plus4, fetch_valid, retired_count, misalign
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: architectural PC register and next-address selection for the
// single-cycle core, with a BOOT/RUN/HALT control FSM and a retire counter.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN -- when defined, a retiring
// target with non-zero low bits redirects to TRAP_PC and sets sticky misalign;
// when undefined, the low two target bits are cleared and misalign stays 0.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0380
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] retired_q;
    logic        fetch_valid_q;
    logic        misalign_q;

    logic [31:0] seq_d;
    logic [31:0] target_d;
    logic [31:0] pc_d;
    logic        misalign_d;

    assign seq_d = pc_q + 32'd4;

    // Select the raw next-PC target from the requested source.
    always_comb begin
        target_d = seq_d;
        case (bus.pc_sel)
            2'b00: target_d = seq_d;
            2'b01: begin
                if (bus.branch_taken) begin
                    target_d = pc_q + bus.imm;
                end else begin
                    target_d = seq_d;
                end
            end
            2'b10: target_d = pc_q + bus.imm;
            2'b11: target_d = (bus.rs1_data + bus.imm) & 32'hFFFF_FFFE;
            default: target_d = seq_d;
        endcase
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned targets divert to the trap vector and raise the sticky flag.
    always_comb begin
        misalign_d = 1'b0;
        pc_d       = target_d;
        if (target_d[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            pc_d       = TRAP_PC;
        end else begin
            misalign_d = 1'b0;
            pc_d       = target_d;
        end
    end
`else
    logic unused_trap_pc;
    assign unused_trap_pc = ^TRAP_PC;

    // Without the trap, force word alignment and never flag.
    always_comb begin
        misalign_d = 1'b0;
        pc_d       = target_d & 32'hFFFF_FFFC;
    end
`endif

    // Control FSM plus PC, retire counter and status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            retired_q     <= 32'd0;
            fetch_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    // halt is deliberately ignored during the boot cycle
                    state_q       <= ST_RUN;
                    fetch_valid_q <= 1'b1;
                end
                ST_RUN: begin
                    if (bus.halt) begin
                        state_q       <= ST_HALT;
                        fetch_valid_q <= 1'b0;
                    end else if (bus.stall) begin
                        state_q       <= ST_RUN;
                        fetch_valid_q <= 1'b1;
                    end else begin
                        state_q       <= ST_RUN;
                        fetch_valid_q <= 1'b1;
                        pc_q          <= pc_d;
                        retired_q     <= retired_q + 32'd1;
                        if (misalign_d) begin
                            misalign_q <= 1'b1;
                        end else begin
                            misalign_q <= misalign_q;
                        end
                    end
                end
                ST_HALT: begin
                    // resume has priority over a concurrent halt request
                    if (bus.resume) begin
                        state_q       <= ST_RUN;
                        fetch_valid_q <= 1'b1;
                    end else begin
                        state_q       <= ST_HALT;
                        fetch_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= ST_BOOT;
                    fetch_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_plus4      = seq_d;
    assign bus.fetch_valid   = fetch_valid_q;
    assign bus.retired_count = retired_q;
    assign bus.misalign      = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
module tb_fetch_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.stall        = 1'b0;
        bus.pc_sel       = 2'b00;
        bus.branch_taken = 1'b0;
        bus.imm          = 32'd0;
        bus.rs1_data     = 32'd0;
        bus.halt         = 1'b0;
        bus.resume       = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_idle();
        tick();
        tick();
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", bus.pc, 32'h0); end
        checks++; if (bus.pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc_plus4: got %h want %h", bus.pc_plus4, 32'h4); end
        checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fetch_valid: got %b want 0", bus.fetch_valid); end
        checks++; if (bus.retired_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.retired_count); end
        checks++; if (bus.misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b want 0", bus.misalign); end
    endtask

    task automatic test_seq();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
        rst_n = 1'b1;
        tick();
        checks++; if (bus.fetch_valid !== 1'b1 || bus.pc !== 32'h0) begin errors++; $display("FAIL boot_exit: got fv=%b pc=%h want fv=1 pc=0", bus.fetch_valid, bus.pc); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.pc !== exp_pc[i]) begin errors++; $display("FAIL seq_pc%0d: got %h want %h", i, bus.pc, exp_pc[i]); end
        end
        checks++; if (bus.retired_count !== 32'd3) begin errors++; $display("FAIL seq_count: got %0d want 3", bus.retired_count); end
    endtask

    task automatic test_redirect();
        tick();
        checks++; if (bus.pc !== 32'h10) begin errors++; $display("FAIL pre_branch_pc: got %h want %h", bus.pc, 32'h10); end
        bus.pc_sel = 2'b01; bus.branch_taken = 1'b1; bus.imm = 32'hFFFF_FFF8;
        tick();
        checks++; if (bus.pc !== 32'h08) begin errors++; $display("FAIL branch_taken_pc: got %h want %h", bus.pc, 32'h08); end
        bus.pc_sel = 2'b10; bus.branch_taken = 1'b0; bus.imm = 32'h8;
        tick();
        checks++; if (bus.pc !== 32'h10) begin errors++; $display("FAIL jal_pc: got %h want %h", bus.pc, 32'h10); end
        bus.pc_sel = 2'b01; bus.branch_taken = 1'b0; bus.imm = 32'hFFFF_FFF8;
        tick();
        checks++; if (bus.pc !== 32'h14) begin errors++; $display("FAIL branch_not_taken_pc: got %h want %h", bus.pc, 32'h14); end
        bus.pc_sel = 2'b11; bus.rs1_data = 32'h41; bus.imm = 32'h4;
        tick();
        checks++; if (bus.pc !== 32'h44) begin errors++; $display("FAIL jalr_pc: got %h want %h", bus.pc, 32'h44); end
        checks++; if (bus.pc_plus4 !== 32'h48) begin errors++; $display("FAIL jalr_pc_plus4: got %h want %h", bus.pc_plus4, 32'h48); end
        checks++; if (bus.retired_count !== 32'd8) begin errors++; $display("FAIL redirect_count: got %0d want 8", bus.retired_count); end
        set_idle();
    endtask

    task automatic test_stall_halt();
        bus.pc_sel = 2'b11; bus.rs1_data = 32'h20; bus.imm = 32'h0;
        tick();
        checks++; if (bus.pc !== 32'h20) begin errors++; $display("FAIL stall_setup_pc: got %h want %h", bus.pc, 32'h20); end
        set_idle();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.pc !== 32'h20 || bus.retired_count !== 32'd9) begin errors++; $display("FAIL stall%0d: got pc=%h cnt=%0d want pc=20 cnt=9", i, bus.pc, bus.retired_count); end
        end
        bus.stall = 1'b0;
        bus.halt = 1'b1;
        tick();
        checks++; if (bus.fetch_valid !== 1'b0 || bus.pc !== 32'h20) begin errors++; $display("FAIL halt_enter: got fv=%b pc=%h want fv=0 pc=20", bus.fetch_valid, bus.pc); end
        bus.halt = 1'b0; bus.pc_sel = 2'b10; bus.imm = 32'h40;
        tick();
        checks++; if (bus.fetch_valid !== 1'b0 || bus.pc !== 32'h20 || bus.retired_count !== 32'd9) begin errors++; $display("FAIL halt_hold: got fv=%b pc=%h cnt=%0d want fv=0 pc=20 cnt=9", bus.fetch_valid, bus.pc, bus.retired_count); end
        bus.resume = 1'b1;
        tick();
        checks++; if (bus.fetch_valid !== 1'b1 || bus.pc !== 32'h20) begin errors++; $display("FAIL resume: got fv=%b pc=%h want fv=1 pc=20", bus.fetch_valid, bus.pc); end
        set_idle();
        bus.halt = 1'b1;
        tick();
        bus.resume = 1'b1;
        tick();
        checks++; if (bus.fetch_valid !== 1'b1 || bus.pc !== 32'h20) begin errors++; $display("FAIL halt_resume_both: got fv=%b pc=%h want fv=1 pc=20", bus.fetch_valid, bus.pc); end
        set_idle();
    endtask

    task automatic test_wrap();
        bus.pc_sel = 2'b11; bus.rs1_data = 32'hFFFF_FFFC; bus.imm = 32'h0;
        tick();
        checks++; if (bus.pc !== 32'hFFFF_FFFC || bus.pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_setup: got pc=%h p4=%h want pc=fffffffc p4=0", bus.pc, bus.pc_plus4); end
        set_idle();
        tick();
        checks++; if (bus.pc !== 32'h0 || bus.retired_count !== 32'd11) begin errors++; $display("FAIL wrap_seq: got pc=%h cnt=%0d want pc=0 cnt=11", bus.pc, bus.retired_count); end
    endtask

    task automatic test_misalign();
        logic [31:0] exp_pc;
        logic        exp_mis;
`ifdef FETCH_MISALIGN_TRAP_EN
        exp_pc = 32'h0000_0380; exp_mis = 1'b1;
`else
        exp_pc = 32'h0000_0100; exp_mis = 1'b0;
`endif
        bus.pc_sel = 2'b11; bus.rs1_data = 32'h100; bus.imm = 32'h0;
        tick();
        bus.pc_sel = 2'b10; bus.rs1_data = 32'h0; bus.imm = 32'h2;
        tick();
        checks++; if (bus.pc !== exp_pc || bus.misalign !== exp_mis) begin errors++; $display("FAIL misalign_jal: got pc=%h mis=%b want pc=%h mis=%b", bus.pc, bus.misalign, exp_pc, exp_mis); end
        checks++; if (bus.retired_count !== 32'd13) begin errors++; $display("FAIL misalign_count: got %0d want 13", bus.retired_count); end
        set_idle();
        for (int i = 0; i < 5; i++) tick();
        checks++; if (bus.misalign !== exp_mis) begin errors++; $display("FAIL misalign_sticky: got %b want %b", bus.misalign, exp_mis); end
    endtask

    task automatic test_mid_reset();
        rst_n = 1'b0;
        bus.pc_sel = 2'b10; bus.imm = 32'h40;
        tick();
        checks++; if (bus.pc !== 32'h0 || bus.retired_count !== 32'd0 || bus.fetch_valid !== 1'b0 || bus.misalign !== 1'b0) begin errors++; $display("FAIL mid_reset: got pc=%h cnt=%0d fv=%b mis=%b want 0 0 0 0", bus.pc, bus.retired_count, bus.fetch_valid, bus.misalign); end
        rst_n = 1'b1;
        set_idle();
        bus.halt = 1'b1;
        tick();
        checks++; if (bus.fetch_valid !== 1'b1 || bus.pc !== 32'h0) begin errors++; $display("FAIL boot_halt_ignored: got fv=%b pc=%h want fv=1 pc=0", bus.fetch_valid, bus.pc); end
        bus.halt = 1'b0;
        tick();
        checks++; if (bus.pc !== 32'h4 || bus.retired_count !== 32'd1) begin errors++; $display("FAIL post_reset_run: got pc=%h cnt=%0d want pc=4 cnt=1", bus.pc, bus.retired_count); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_seq();
        test_redirect();
        test_stall_halt();
        test_wrap();
        test_misalign();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and next-address stage directly upstream of the instruction memory in the single-cycle core. It holds the architectural PC, drives it as the byte address into instruction memory, and computes the next PC from sequential, branch, JAL and JALR sources. It also provides a boot/run/halt control FSM, an instruction-retire counter, and an optional misaligned-target trap.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_PC, 32'h0000_0380, redirect target for a misaligned fetch (only with FETCH_MISALIGN_TRAP_EN).
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset; the only clock is clk.
- stall  in  1  hold the PC and do not retire this cycle.
- pc_sel  in  2  next-PC source: 00 = seq, 01 = branch, 10 = jal, 11 = jalr.
- branch_taken  in  1  qualifies pc_sel=01.
- imm  in  32  sign-extended immediate from decode.
- rs1_data  in  32  register operand for JALR.
- halt  in  1  request to enter HALT.
- resume  in  1  request to leave HALT.
- pc  out  32  current PC; drives the instruction-memory addr.
- pc_plus4  out  32  pc + 4, combinational, for the link register.
- fetch_valid  out  1  the instruction at pc executes this cycle.
- retired_count  out  32  count of retired instructions.
- misalign  out  1  sticky misaligned-target flag.

## Operation
- FSM states:
  - BOOT: entered on reset; fetch_valid=0; moves to RUN next cycle unconditionally.
  - RUN: fetch_valid=1.
  - HALT: fetch_valid=0; pc frozen; resume=1 moves to RUN next cycle.
- Priority within RUN: halt > stall > pc_sel.
  - halt=1: the current instruction does not retire, pc is held, next state is HALT.
  - stall=1: pc is held, no retire.
- Target computation, all 32-bit modulo 2^32:
  - seq: pc+4.
  - branch: pc+imm if branch_taken, else pc+4.
  - jal: pc+imm.
  - jalr: (rs1_data+imm) & ~32'h1.
- Retire: in RUN with halt=0 and stall=0, pc <= target and retired_count increments. The counter wraps from 32'hFFFF_FFFF to 0.
- Wrap-around: pc=32'hFFFF_FFFC, seq → 32'h0000_0000. No error is raised.
- Inputs pc_sel, branch_taken, imm, rs1_data and stall are ignored in BOOT and HALT.
- halt and resume asserted together in HALT: resume wins, next state is RUN.
- halt asserted in BOOT: ignored; the FSM still moves to RUN.

## Timing
- All state updates on the rising edge of clk; no combinational path from inputs to pc.
- Reset (rst_n=0 sampled at an edge) produces:
  - pc=RESET_PC, pc_plus4=RESET_PC+4
  - retired_count=0, misalign=0
  - state BOOT, fetch_valid=0
- Reset asserted mid-operation overrides everything in that cycle.
- Latency: the new pc is visible one cycle after the retiring edge. The instruction memory is combinational, so the next instruction is available in the same cycle pc changes.
- First valid fetch is the second cycle after reset release (one BOOT cycle).
- Halt takes effect at the edge after halt is sampled. Resume: fetch_valid=1 in the cycle after resume is sampled, with pc unchanged.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A retiring target with target[1:0] != 00 loads pc=TRAP_PC instead of the target.
  - misalign is set and stays 1 until reset.
  - The instruction still counts as retired.
- FETCH_MISALIGN_TRAP_EN undefined:
  - The target is loaded with bits [1:0] forced to 00.
  - misalign is tied to 0.

## Test plan
- Reset then free-run with pc_sel=00, no stall: pc = 0 in BOOT, then 0, 4, 8, 12 in RUN; retired_count = 3 after three RUN edges.
- Redirects:
  - pc=0x10, pc_sel=01, branch_taken=1, imm=0xFFFF_FFF8 → pc=0x08.
  - Same with branch_taken=0 → pc=0x14.
  - pc_sel=11, rs1_data=0x41, imm=0x4 → pc=0x44.
- Stall and halt:
  - stall=1 for 3 cycles at pc=0x20 → pc stays 0x20 and retired_count unchanged.
  - halt pulse → fetch_valid=0 next cycle; resume → fetch_valid=1 at pc=0x20.
- Wrap-around and mid-run reset:
  - Force pc=0xFFFF_FFFC, seq → pc=0.
  - rst_n=0 for one cycle mid-run → pc=RESET_PC, retired_count=0, BOOT.
- Misaligned JAL target 0x102:
  - With FETCH_MISALIGN_TRAP_EN: pc=0x380, misalign=1, still 1 after 5 cycles.
  - Without the macro: pc=0x100, misalign=0.
